// File: rtl/mips_pkg.sv
// Definitions shared by the fetch stage and the control unit: jump select
// encodings, opcode constants and the fetch sequencer state type.
package mips_pkg;

    localparam logic [1:0] JUMP_SEQ = 2'b00;
    localparam logic [1:0] JUMP_J   = 2'b01;
    localparam logic [1:0] JUMP_JR  = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [31:0] INSTR_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_ERR   = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, jump register, taken branch or pc+4.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  Jump,
    input  logic        Branch,
    input  logic        branch_taken,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4_s;
    logic [31:0] branch_off_s;
    logic        unused_s;

    assign pc_plus4_s   = pc + INSTR_STEP;
    assign branch_off_s = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign unused_s     = &{1'b0, instr[31:26], rs_data[1:0]};

    // Jump decode comes first so Branch is never looked at for J/JR.
    always_comb begin
        next_pc = pc_plus4_s;
        case (Jump)
            JUMP_J:  next_pc = {pc_plus4_s[31:28], instr[25:0], 2'b00};
            JUMP_JR: next_pc = {rs_data[31:2], 2'b00};
            default: begin
                if (Branch && branch_taken) begin
                    next_pc = pc_plus4_s + branch_off_s;
                end else begin
                    next_pc = pc_plus4_s;
                end
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing: owns the PC, fetches over the imem
// handshake, holds the instruction until the control unit advances.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    fetch_unit_if.master imem,
    input  logic        pc_load,
    input  logic [1:0]  Jump,
    input  logic        Branch,
    input  logic        branch_taken,
    input  logic        PC_Store,
    input  logic [31:0] rs_data,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        fetch_err
);

    localparam logic [7:0] TIMEOUT_C = 8'(ACK_TIMEOUT);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic [31:0]  pc_r;
    logic [31:0]  instr_r;
    logic [7:0]   wait_cnt_r;
    logic [7:0]   wait_cnt_nxt_s;
    logic         fetch_err_r;
    logic         capture_s;
    logic         advance_s;
    logic         err_set_s;
    logic [31:0]  next_pc_s;
    logic         unused_s;

    // PC_Store only matters to the register-file writeback, which uses link_addr.
    assign unused_s = &{1'b0, PC_Store};

    next_pc_calc u_next_pc (
        .pc           (pc_r),
        .instr        (instr_r),
        .Jump         (Jump),
        .Branch       (Branch),
        .branch_taken (branch_taken),
        .rs_data      (rs_data),
        .next_pc      (next_pc_s)
    );

    // Sequencer state register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; an ack on the timeout edge still wins over the error.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        capture_s      = 1'b0;
        advance_s      = 1'b0;
        err_set_s      = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    capture_s      = 1'b1;
                    wait_cnt_nxt_s = 8'd0;
                    state_nxt_s    = ST_EXEC;
                end else if ((wait_cnt_r + 8'd1) == TIMEOUT_C) begin
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                    err_set_s      = 1'b1;
                    state_nxt_s    = ST_ERR;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                end
            end
            ST_EXEC: begin
                if (pc_load) begin
                    advance_s   = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // PC, held instruction, wait counter and sticky error flag.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_r        <= RESET_PC;
            instr_r     <= 32'd0;
            wait_cnt_r  <= 8'd0;
            fetch_err_r <= 1'b0;
        end else begin
            if (capture_s) begin
                instr_r <= imem.imem_rdata;
            end
            if (advance_s) begin
                pc_r <= next_pc_s;
            end
            if (err_set_s) begin
                fetch_err_r <= 1'b1;
            end
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    assign imem.imem_req  = (state_r == ST_FETCH);
    assign imem.imem_addr = pc_r;
    assign instr_valid    = (state_r == ST_EXEC);
    assign instr          = instr_r;
    assign opcode         = instr_r[31:26];
    assign funct          = instr_r[5:0];
    assign pc             = pc_r;
    assign link_addr      = pc_r + INSTR_STEP;
    assign fetch_err      = fetch_err_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a driver plays memory and control
// unit, a negedge monitor checks every EXEC cycle against a reference PC model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        Clock;
    logic        Reset;
    logic        pc_load;
    logic [1:0]  Jump;
    logic        Branch;
    logic        branch_taken;
    logic        PC_Store;
    logic [31:0] rs_data;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        fetch_err;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_PC(RST_PC), .ACK_TIMEOUT(15)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .imem         (imem_bus),
        .pc_load      (pc_load),
        .Jump         (Jump),
        .Branch       (Branch),
        .branch_taken (branch_taken),
        .PC_Store     (PC_Store),
        .rs_data      (rs_data),
        .instr        (instr),
        .opcode       (opcode),
        .funct        (funct),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .link_addr    (link_addr),
        .fetch_err    (fetch_err)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [31:0] model_pc;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference next PC from the instruction-set rules.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic [1:0] jmp, input logic br,
                                             input logic tk, input logic [31:0] rs);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        if (jmp == 2'b01) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        if (jmp == 2'b10) return rs & 32'hFFFF_FFFC;
        if (br && tk) begin
            off = int'($signed(word[15:0]));
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    // Monitor: every EXEC cycle must present the oldest outstanding fetch.
    always @(negedge Clock) begin
        if (Reset && instr_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
                chk("pc", pc, exp_q[0].pc);
                chk("instr", instr, exp_q[0].word);
                chk("opcode", {26'd0, opcode}, {26'd0, exp_q[0].word[31:26]});
                chk("funct", {26'd0, funct}, {26'd0, exp_q[0].word[5:0]});
                chk("link_addr", link_addr, exp_q[0].pc + 32'd4);
                if (pc_load) exp_q.pop_front();
            end
        end
    end

    task automatic wait_req();
        int n;
        n = 0;
        while (!imem_bus.imem_req && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
        chk("req_seen", {31'd0, imem_bus.imem_req}, 32'd1);
        chk("imem_addr", imem_bus.imem_addr, model_pc);
    endtask

    task automatic do_instr(input logic [31:0] word, input int dly, input int stall,
                            input logic [1:0] jmp, input logic br, input logic tk,
                            input logic [31:0] rs, input bit exec_ack);
        wait_req();
        repeat (dly) begin
            @(posedge Clock); #1;
            chk("req_held", {31'd0, imem_bus.imem_req}, 32'd1);
            chk("addr_held", imem_bus.imem_addr, model_pc);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = word;
        exp_q.push_back('{pc: model_pc, word: word});
        @(posedge Clock); #1;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = $urandom;
        chk("req_drop", {31'd0, imem_bus.imem_req}, 32'd0);
        repeat (stall) begin
            Jump         = 2'($urandom);
            Branch       = 1'($urandom);
            branch_taken = 1'($urandom);
            rs_data      = $urandom;
            imem_bus.imem_ack = exec_ack;
            @(posedge Clock); #1;
            imem_bus.imem_ack = 1'b0;
            chk("stall_req", {31'd0, imem_bus.imem_req}, 32'd0);
        end
        Jump         = jmp;
        Branch       = br;
        branch_taken = tk;
        rs_data      = rs;
        PC_Store     = (jmp == 2'b01);
        pc_load      = 1'b1;
        model_pc     = ref_next(model_pc, word, jmp, br, tk, rs);
        @(posedge Clock); #1;
        pc_load = 1'b0;
        chk("req_rerise", {31'd0, imem_bus.imem_req}, 32'd1);
    endtask

    task automatic apply_reset();
        Reset = 1'b0;
        imem_bus.imem_ack = 1'b0;
        pc_load = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_link", link_addr, RST_PC + 32'd4);
        chk("rst_instr", instr, 32'd0);
        chk("rst_opfn", {20'd0, opcode, funct}, 32'd0);
        chk("rst_flags", {29'd0, imem_bus.imem_req, instr_valid, fetch_err}, 32'd0);
        exp_q.delete();
        model_pc = RST_PC;
        Reset = 1'b1;
        chk("boot_req", {31'd0, imem_bus.imem_req}, 32'd0);
        @(posedge Clock); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        pc_load = 1'b0;
        Jump = 2'b00;
        Branch = 1'b0;
        branch_taken = 1'b0;
        PC_Store = 1'b0;
        rs_data = 32'd0;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = 32'd0;
        model_pc = RST_PC;
        apply_reset();

        do_instr(32'h2008000A, 0, 0, 2'b00, 1'b0, 1'b0, 32'd0, 1'b0);
        do_instr(32'h0000_0008, 1, 0, 2'b10, 1'b0, 1'b0, 32'h10, 1'b0);
        do_instr(32'h1000FFFE, 0, 1, 2'b00, 1'b1, 1'b1, 32'd0, 1'b0);
        chk("branch_taken_pc", model_pc, 32'h0000_000C);
        do_instr(32'h0000_0008, 0, 0, 2'b10, 1'b0, 1'b0, 32'h10, 1'b0);
        do_instr(32'h1000FFFE, 2, 0, 2'b00, 1'b1, 1'b0, 32'd0, 1'b0);
        do_instr(32'h0000_0008, 0, 0, 2'b10, 1'b0, 1'b0, 32'h40, 1'b0);
        do_instr(32'h0C000100, 0, 0, 2'b01, 1'($urandom), 1'b1, 32'd0, 1'b0);
        do_instr(32'h0000_0008, 0, 0, 2'b10, 1'b1, 1'b1, 32'h123, 1'b0);
        do_instr(32'h0000_0008, 0, 0, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0);
        do_instr(32'h2108_0001, 0, 3, 2'b11, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_pc", model_pc, 32'h0000_0000);

        for (int i = 0; i < 40; i++) begin
            do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2), 2'($urandom),
                     1'($urandom), 1'($urandom), $urandom, 1'($urandom));
        end

        // Ack withheld: error on the fifteenth waiting edge, then stuck.
        wait_req();
        repeat (14) @(posedge Clock);
        #1;
        chk("err_early", {30'd0, fetch_err, imem_bus.imem_req}, 32'd1);
        @(posedge Clock); #1;
        chk("err_set", {29'd0, fetch_err, imem_bus.imem_req, instr_valid}, 32'd4);
        imem_bus.imem_ack = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        imem_bus.imem_ack = 1'b0;
        chk("err_stuck", {29'd0, fetch_err, imem_bus.imem_req, instr_valid}, 32'd4);

        apply_reset();
        do_instr($urandom, 0, 0, 2'b00, 1'b0, 1'b0, 32'd0, 1'b0);
        wait_req();
        #2;
        imem_bus.imem_ack = 1'b1;
        Reset = 1'b0;
        #1;
        chk("async_req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("async_pc", pc, RST_PC);
        apply_reset();
        do_instr($urandom, 1, 1, 2'b00, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("after_reset_pc", model_pc, RST_PC + 32'd4);

        repeat (2) @(posedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and PC-sequencing stage that feeds the control unit. It drives `opcode`/`funct` into the control unit and consumes `pc_load`, `Jump`, `Branch` and `PC_Store` back from it. It owns the program counter, fetches instructions over a req/ack instruction-memory handshake, holds the current instruction until the control unit releases it, and computes the next PC for sequential, branch, jump and jump-register flow.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Word aligned.
- `ACK_TIMEOUT`, default 15: maximum wait cycles for `imem_ack` before `fetch_err` is raised. Range 1–255.
- `Clock`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low (0 = in reset).
- `imem_req`  out  1  fetch request; held until ack.
- `imem_addr`  out  32  byte address. Equals `pc`, stable while `imem_req`=1.
- `imem_ack`  in  1  fetch done; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `pc_load`  in  1  from control unit: 1 = advance, 0 = stall.
- `Jump`  in  2  00 = sequential/branch, 01 = J/JAL target, 10 = JR, 11 = treated as 00.
- `Branch`  in  1  branch instruction.
- `branch_taken`  in  1  comparison result from ALU.
- `PC_Store`  in  1  JAL; informational only, no internal effect.
- `rs_data`  in  32  register value used for JR.
- `instr`  out  32  held instruction.
- `opcode`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `instr_valid`  out  1  `instr` is current and must be decoded.
- `pc`  out  32  address of the held instruction.
- `link_addr`  out  32  `pc`+4, used for the JAL writeback.
- `fetch_err`  out  1  sticky fetch timeout.

## Operation
- State machine with states BOOT, FETCH, EXEC and ERR. The reset state is BOOT.
  - BOOT → FETCH on the first edge after reset is released.
  - FETCH: `imem_req`=1. On an edge with `imem_ack`=1: capture `imem_rdata` into `instr`, clear the wait counter, go to EXEC.
  - FETCH, no ack: the wait counter increments. On the edge where the counter reaches `ACK_TIMEOUT`, go to ERR and set `fetch_err`.
  - EXEC: `instr_valid`=1. On an edge with `pc_load`=1: `pc` ← next PC, go to FETCH. With `pc_load`=0, stay in EXEC; `pc`, `instr` and `instr_valid` hold.
  - ERR: terminal. `imem_req`=0, `instr_valid`=0. Only reset leaves ERR.
- Next-PC priority (all arithmetic is 32-bit modulo 2^32, so it wraps):
  1. `Jump`=01: {(pc+4)[31:28], instr[25:0], 2'b00}.
  2. `Jump`=10: {rs_data[31:2], 2'b00}. Misaligned low bits are forced to 0.
  3. `Branch`=1 and `branch_taken`=1: pc + 4 + (sext(instr[15:0]) << 2).
  4. Otherwise: pc + 4.
- `Branch` is ignored whenever `Jump` is 01 or 10, including when `Branch` is X.
- `imem_ack` is ignored outside FETCH.

## Timing
- Reset values (held while `Reset`=0):
  - `pc`=`RESET_PC`, `link_addr`=`RESET_PC`+4.
  - `instr`=0, `opcode`=0, `funct`=0.
  - `imem_req`=0, `instr_valid`=0, `fetch_err`=0, wait counter=0.
- Asserting reset mid-fetch drops `imem_req` immediately (asynchronous); an ack arriving during reset is discarded.
- A zero-wait memory (ack in the first FETCH cycle) gives 2 cycles per instruction: FETCH then EXEC.
- `instr_valid` rises the cycle after the ack edge.
- `imem_req` drops the cycle after the ack edge and re-rises the cycle after the `pc_load` edge.
- `opcode`, `funct`, `link_addr` and `imem_addr` are combinational from registers, so they are glitch-free relative to the control unit.
- Control inputs are sampled only at the EXEC edge where `pc_load`=1.

## Structure
- Shared `mips_pkg` holds:
  - `Jump` encodings: JUMP_SEQ, JUMP_J, JUMP_JR.
  - Opcode constants shared with the control unit.
  - The fetch state enum.
- One combinational sub-module, `next_pc_calc`: inputs `pc`, `instr`, `Jump`, `Branch`, `branch_taken`, `rs_data`; output is the next PC.

## Test plan
- Reset release with `RESET_PC`=0: one BOOT cycle, then `imem_req`=1 at `imem_addr` 0x0. Ack with 0x2008000A → next cycle `instr_valid`=1, `opcode`=0x08, `funct`=0x0A. Then `pc_load`=1 → `imem_addr`=0x4.
- At `pc`=0x10, `instr`=0x1000FFFE, `Branch`=1: with `branch_taken`=1 → next fetch at 0x0C; with `branch_taken`=0 → next fetch at 0x14.
- At `pc`=0x40, `instr`=0x0C000100 (JAL), `Jump`=01, `Branch`=X → `link_addr`=0x44, next fetch at 0x400.
- `instr`=0x00000008 (JR), `Jump`=10, `rs_data`=0x123 → next fetch at 0x120. At `pc`=0xFFFFFFFC with sequential flow → wraps to 0x0.
- Hold `pc_load`=0 for 3 EXEC cycles → `imem_req`=0 and `pc`/`instr` unchanged throughout. An ack pulse during EXEC is ignored.
- Withhold ack → after 15 wait cycles `fetch_err`=1 and `imem_req`=0, stuck in ERR. Pulse `Reset` low mid-fetch → outputs return to reset values immediately.
